qupls4_reservation_station: RTL and testbench

- Per-functional-unit reservation station directly downstream of the instruction dispatcher.
- Accepts one reservation_station_entry_t per cycle from the dispatcher's registered output slot assigned to this unit.
- Holds up to NENTRIES entries and captures missing source operands from result-bus wakeup broadcasts.
- Issues the oldest fully-ready entry to its functional unit when the unit accepts. Reports busy back to the dispatcher.

---
 rtl/qupls4_pkg.sv | 35 +++
 rtl/qupls4_rs_wakeup.sv | 30 +++
 rtl/qupls4_reservation_station.sv | 145 ++++++++++++++
 tb/tb_qupls4_reservation_station.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qupls4_pkg.sv
// Shared types for the Qupls4 reservation station: dispatcher entry layout,
// wakeup bus format and per-slot age counter.
package qupls4_pkg;

  localparam int ROB_ENTRIES = 16;
  localparam int RS_NENTRIES = 4;

  typedef logic [$clog2(ROB_ENTRIES)-1:0] rob_ndx_t;
  typedef logic [2:0]                     rs_age_t;

  typedef struct packed {
    logic        v;
    logic [8:0]  prn;
    logic [63:0] val;
  } wake_bus_t;

  typedef struct packed {
    logic        v;
    logic [8:0]  prn;
    logic [63:0] val;
  } rs_arg_t;

  // arg[0..3] sources, arg[4] target, arg[5] status
  typedef struct packed {
    logic [7:0]    op;
    logic [3:0]    funcunit;
    rob_ndx_t      rndx;
    rs_arg_t [5:0] arg;
  } reservation_station_entry_t;

  function automatic rs_age_t age_inc(rs_age_t a);
    return (a == 3'd7) ? a : a + 3'd1;
  endfunction

endpackage

// File: rtl/qupls4_rs_wakeup.sv
// Combinational operand capture for one entry: any invalid arg whose tag
// matches a live wakeup bus becomes valid with that bus's value.
module qupls4_rs_wakeup
  import qupls4_pkg::*;
#(
  parameter int NWAKE = 4
) (
  input  reservation_station_entry_t i_rse,
  input  wake_bus_t [NWAKE-1:0]      i_wake,
  output reservation_station_entry_t o_rse
);

  // NOTE: combinational blocks use blocking '=' and assign a full default
  // first, so every path drives o_rse and no latch is inferred.
  always_comb begin
    o_rse = i_rse;
    for (int a = 0; a < 6; a++) begin
      if (!i_rse.arg[a].v && i_rse.arg[a].prn != '0) begin
        // Walk buses high to low so the lowest-index match is the one kept.
        for (int b = NWAKE-1; b >= 0; b--) begin
          if (i_wake[b].v && i_wake[b].prn == i_rse.arg[a].prn) begin
            o_rse.arg[a].v   = 1'b1;
            o_rse.arg[a].val = i_wake[b].val;
          end
        end
      end
    end
  end

endmodule

// File: rtl/qupls4_reservation_station.sv
// Per-functional-unit reservation station: holds dispatched entries, snoops
// result buses for operands and issues the oldest ready entry.
module qupls4_reservation_station
  import qupls4_pkg::*;
#(
  parameter int          NENTRIES = RS_NENTRIES,
  parameter int          NWAKE    = 4,
  parameter logic [3:0]  FUNCUNIT = 4'd0,
  parameter int          NSRC     = 4,
  localparam int         OCC_W    = $clog2(NENTRIES+1),
  localparam int         IDX_W    = $clog2(NENTRIES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ld_v,
  input  reservation_station_entry_t  ld_rse,
  input  logic [NWAKE-1:0]            wake_v,
  input  logic [NWAKE-1:0][8:0]       wake_prn,
  input  logic [NWAKE-1:0][63:0]      wake_val,
  input  logic [ROB_ENTRIES-1:0]      stomp,
  input  logic                        fu_rdy,
  output logic                        iss_v,
  output reservation_station_entry_t  iss_rse,
  output logic                        busy,
  output logic                        ovf,
  output logic [OCC_W-1:0]            occ
);

  logic [NENTRIES-1:0]        r_valid;
  reservation_station_entry_t r_slot [NENTRIES];
  rs_age_t                    r_age  [NENTRIES];
  logic                       r_iss_v, r_busy, r_ovf;
  reservation_station_entry_t r_iss_rse;
  logic [OCC_W-1:0]           r_occ;

  wake_bus_t [NWAKE-1:0]      w_wake;
  reservation_station_entry_t w_merged [NENTRIES];
  reservation_station_entry_t w_ld_merged;
  logic [NENTRIES-1:0]        w_stomped;
  logic                       w_any_rdy, w_issue, w_has_free;
  logic                       w_ld_match, w_ld_acc, w_ld_ovf;
  logic [IDX_W-1:0]           w_sel, w_free_idx;
  rs_age_t                    w_best_age;
  logic [OCC_W-1:0]           w_stomp_cnt, w_occ_next;

  for (genvar b = 0; b < NWAKE; b++) begin : g_bus
    assign w_wake[b] = '{v: wake_v[b], prn: wake_prn[b], val: wake_val[b]};
  end

  for (genvar g = 0; g < NENTRIES; g++) begin : g_slot
    qupls4_rs_wakeup #(.NWAKE(NWAKE)) u_wake (
      .i_rse (r_slot[g]),
      .i_wake(w_wake),
      .o_rse (w_merged[g])
    );
  end

  qupls4_rs_wakeup #(.NWAKE(NWAKE)) u_ld_wake (
    .i_rse (ld_rse),
    .i_wake(w_wake),
    .o_rse (w_ld_merged)
  );

  function automatic logic args_ready(reservation_station_entry_t e);
    logic ok;
    ok = e.arg[4].v & e.arg[5].v;
    for (int a = 0; a < NSRC; a++) ok = ok & e.arg[a].v;
    return ok;
  endfunction

  always_comb begin
    w_stomped   = '0;
    w_any_rdy   = 1'b0;
    w_sel       = '0;
    w_best_age  = '0;
    w_has_free  = 1'b0;
    w_free_idx  = '0;
    w_stomp_cnt = '0;
    for (int i = 0; i < NENTRIES; i++) begin
      w_stomped[i] = r_valid[i] && stomp[r_slot[i].rndx];
      // Strict '>' while scanning upward leaves ties with the lower index.
      if (r_valid[i] && !w_stomped[i] && args_ready(w_merged[i]) &&
          (!w_any_rdy || r_age[i] > w_best_age)) begin
        w_any_rdy  = 1'b1;
        w_sel      = IDX_W'(i);
        w_best_age = r_age[i];
      end
      if (!r_valid[i] && !w_has_free) begin
        w_has_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      w_stomp_cnt = w_stomp_cnt + OCC_W'(w_stomped[i]);
    end
    w_issue    = w_any_rdy && fu_rdy;
    w_ld_match = ld_v && (ld_rse.funcunit == FUNCUNIT);
    w_ld_acc   = w_ld_match && w_has_free && !stomp[ld_rse.rndx];
    w_ld_ovf   = w_ld_match && !w_has_free;
    w_occ_next = r_occ + OCC_W'(w_ld_acc) - OCC_W'(w_issue) - w_stomp_cnt;
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= '0;
      r_iss_v   <= 1'b0;
      r_iss_rse <= '0;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
      r_occ     <= '0;
      for (int i = 0; i < NENTRIES; i++) r_age[i] <= '0;
    end else begin
      if (w_ld_acc)
        for (int i = 0; i < NENTRIES; i++)
          if (r_valid[i]) r_age[i] <= age_inc(r_age[i]);
      r_valid <= r_valid & ~w_stomped;
      if (w_issue) r_valid[w_sel] <= 1'b0;
      if (w_ld_acc) begin
        r_valid[w_free_idx] <= 1'b1;
        r_age[w_free_idx]   <= '0;
      end
      r_iss_v <= w_issue;
      if (w_issue) r_iss_rse <= w_merged[w_sel];
      r_busy <= (w_occ_next == OCC_W'(NENTRIES)) ||
                ((w_occ_next == OCC_W'(NENTRIES-1)) && w_ld_acc);
      if (w_ld_ovf) r_ovf <= 1'b1;
      r_occ <= w_occ_next;
    end
  end

  // NOTE: slot payload is deliberately not reset; r_valid gates every use,
  // so the wide entry storage needs no reset wiring.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NENTRIES; i++)
      if (r_valid[i]) r_slot[i] <= w_merged[i];
    if (w_ld_acc) r_slot[w_free_idx] <= w_ld_merged;
  end

  assign iss_v   = r_iss_v;
  assign iss_rse = r_iss_rse;
  assign busy    = r_busy;
  assign ovf     = r_ovf;
  assign occ     = r_occ;

endmodule

// File: tb/tb_qupls4_reservation_station.sv
// Scoreboard bench for the reservation station: directed scenarios then random
// traffic, all compared against a slot-list reference model.
module tb_qupls4_reservation_station;
  import qupls4_pkg::*;

  localparam int N  = 4;
  localparam int NW = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       ld_v = 1'b0;
  reservation_station_entry_t ld_rse = '0;
  logic [NW-1:0]              wake_v = '0;
  logic [NW-1:0][8:0]         wake_prn = '0;
  logic [NW-1:0][63:0]        wake_val = '0;
  logic [ROB_ENTRIES-1:0]     stomp = '0;
  logic                       fu_rdy = 1'b0;
  logic                       iss_v;
  reservation_station_entry_t iss_rse;
  logic                       busy, ovf;
  logic [2:0]                 occ;

  qupls4_reservation_station #(.NENTRIES(N), .NWAKE(NW), .FUNCUNIT(4'd0), .NSRC(4)) dut (
    .clk(clk), .rst(rst), .ld_v(ld_v), .ld_rse(ld_rse),
    .wake_v(wake_v), .wake_prn(wake_prn), .wake_val(wake_val),
    .stomp(stomp), .fu_rdy(fu_rdy),
    .iss_v(iss_v), .iss_rse(iss_rse), .busy(busy), .ovf(ovf), .occ(occ)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  reservation_station_entry_t exp_q[$];
  reservation_station_entry_t m_last = '0;

  // Reference model: slot occupancy, contents and load sequence numbers.
  bit                         m_v   [N];
  reservation_station_entry_t m_e   [N];
  int                         m_seq [N];
  int                         m_loads = 0;
  int                         m_occ = 0;
  bit                         m_busy = 1'b0;
  bit                         m_ovf = 1'b0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic reservation_station_entry_t wake_merge(reservation_station_entry_t e);
    for (int a = 0; a < 6; a++) begin
      if (!e.arg[a].v && e.arg[a].prn != 9'd0) begin
        for (int b = 0; b < NW; b++) begin
          if (wake_v[b] && wake_prn[b] == e.arg[a].prn) begin
            e.arg[a].v   = 1'b1;
            e.arg[a].val = wake_val[b];
            break;
          end
        end
      end
    end
    return e;
  endfunction

  function automatic bit all_ready(reservation_station_entry_t e);
    for (int a = 0; a < 6; a++) if (!e.arg[a].v) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_age(int i);
    int d;
    d = m_loads - m_seq[i];
    return (d > 7) ? 7 : d;
  endfunction

  // Advances the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    bit old_v [N];
    int sel, best, free, cnt;
    bit ld_acc;
    old_v = m_v;
    sel = -1; best = -1; free = -1; ld_acc = 1'b0;
    for (int i = 0; i < N; i++) if (m_v[i]) m_e[i] = wake_merge(m_e[i]);
    for (int i = 0; i < N; i++) if (m_v[i] && stomp[m_e[i].rndx]) m_v[i] = 1'b0;
    if (fu_rdy)
      for (int i = 0; i < N; i++)
        if (m_v[i] && all_ready(m_e[i]) && m_age(i) > best) begin
          best = m_age(i);
          sel  = i;
        end
    if (sel >= 0) begin
      exp_q.push_back(m_e[sel]);
      m_v[sel] = 1'b0;
    end
    if (ld_v && ld_rse.funcunit == 4'd0) begin
      for (int i = 0; i < N; i++) if (!old_v[i] && free < 0) free = i;
      if (free < 0) m_ovf = 1'b1;
      else if (!stomp[ld_rse.rndx]) begin
        ld_acc = 1'b1;
        m_v[free] = 1'b1;
        m_e[free] = wake_merge(ld_rse);
        m_loads++;
        m_seq[free] = m_loads;
      end
    end
    cnt = 0;
    for (int i = 0; i < N; i++) if (m_v[i]) cnt++;
    m_occ  = cnt;
    m_busy = (cnt == N) || (cnt == N-1 && ld_acc);
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    check("occ", occ, m_occ);
    check("busy", busy, m_busy);
    check("ovf", ovf, m_ovf);
  endtask

  task automatic idle();
    ld_v = 1'b0; wake_v = '0; stomp = '0; fu_rdy = 1'b0;
  endtask

  function automatic reservation_station_entry_t mk_ready(input int rndx, input int op);
    reservation_station_entry_t e;
    e.op = 8'(op); e.funcunit = 4'd0; e.rndx = rob_ndx_t'(rndx);
    for (int a = 0; a < 6; a++) begin
      e.arg[a].v = 1'b1; e.arg[a].prn = 9'(a + 1); e.arg[a].val = {$urandom, $urandom};
    end
    return e;
  endfunction

  function automatic reservation_station_entry_t rand_entry();
    reservation_station_entry_t e;
    e.op = 8'($urandom);
    e.funcunit = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    e.rndx = rob_ndx_t'($urandom_range(0, 15));
    for (int a = 0; a < 6; a++) begin
      e.arg[a].v   = ($urandom_range(0, 2) != 0);
      e.arg[a].prn = ($urandom_range(0, 63) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
      e.arg[a].val = {$urandom, $urandom};
    end
    return e;
  endfunction

  // Monitor: every issue must match the next expected entry; idle cycles hold.
  initial forever begin
    @(negedge clk);
    if (!rst) m_last = '0;
    else if (iss_v) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL iss_unexpected got iss_v=1 rse=%0h expected no issue", iss_rse);
      end else begin
        m_last = exp_q.pop_front();
        check("iss_rse", iss_rse, m_last);
      end
    end else check("iss_hold", iss_rse, m_last);
  end

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_iss_v", iss_v, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_occ", occ, 3'd0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_iss_rse", iss_rse, '0);
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_loads = 0; m_occ = 0; m_busy = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    reservation_station_entry_t e;
    for (int i = 0; i < N; i++) begin m_v[i] = 1'b0; m_seq[i] = 0; end
    @(negedge clk);
    do_reset();

    // All args valid: issues on the edge after the load edge.
    idle(); fu_rdy = 1'b1; ld_v = 1'b1; ld_rse = mk_ready(1, 8'h11); step();
    check("t1_no_iss_yet", iss_v, 1'b0);
    idle(); fu_rdy = 1'b1; step();
    check("t1_iss_v", iss_v, 1'b1);
    idle(); step();

    // Operand captured from bus 2 three cycles after the load.
    e = mk_ready(2, 8'h22); e.arg[1].v = 1'b0; e.arg[1].prn = 9'd37;
    idle(); fu_rdy = 1'b1; ld_v = 1'b1; ld_rse = e; step();
    idle(); fu_rdy = 1'b1; step();
    idle(); fu_rdy = 1'b1; step();
    idle(); fu_rdy = 1'b1; wake_v[2] = 1'b1; wake_prn[2] = 9'd37; wake_val[2] = 64'hDEAD; step();
    check("t2_iss_v", iss_v, 1'b1);
    check("t2_val", iss_rse.arg[1].val, 64'hDEAD);

    // Fill, then overflow.
    for (int k = 0; k < 5; k++) begin
      idle(); ld_v = 1'b1; ld_rse = mk_ready(k + 3, 8'h30 + k); step();
    end
    check("t3_ovf", ovf, 1'b1);
    check("t3_occ", occ, 3'd4);
    for (int k = 0; k < 4; k++) begin idle(); fu_rdy = 1'b1; step(); end

    // Oldest first.
    idle(); ld_v = 1'b1; ld_rse = mk_ready(8, 8'h40); step();
    idle(); ld_v = 1'b1; ld_rse = mk_ready(9, 8'h41); step();
    idle(); step();
    idle(); fu_rdy = 1'b1; step();
    check("t4_first", iss_rse.op, 8'h40);
    idle(); fu_rdy = 1'b1; step();
    check("t4_second", iss_rse.op, 8'h41);

    // Stomp of a waiting entry; later wakeup must not resurrect it.
    e = mk_ready(5, 8'h55); e.arg[0].v = 1'b0; e.arg[0].prn = 9'd50;
    idle(); ld_v = 1'b1; ld_rse = e; step();
    idle(); stomp[5] = 1'b1; step();
    check("t5_occ", occ, 3'd0);
    for (int k = 0; k < 3; k++) begin
      idle(); fu_rdy = 1'b1; wake_v[0] = 1'b1; wake_prn[0] = 9'd50; step();
      check("t5_no_iss", iss_v, 1'b0);
    end

    // Asynchronous reset with entries in flight and ovf set.
    for (int k = 0; k < 5; k++) begin
      idle(); ld_v = 1'b1; ld_rse = mk_ready(k, 8'h60 + k); step();
    end
    idle(); fu_rdy = 1'b1; step();
    check("t6_pre_iss", iss_v, 1'b1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle(); fu_rdy = 1'b1; step();
      check("t6_no_iss", iss_v, 1'b0);
    end

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      ld_v   = ($urandom_range(0, 2) != 0);
      ld_rse = rand_entry();
      fu_rdy = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NW; b++) begin
        wake_v[b]   = $urandom_range(0, 1);
        wake_prn[b] = 9'($urandom_range(1, 12));
        wake_val[b] = {$urandom, $urandom};
      end
      stomp = ($urandom_range(0, 3) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0;
      step();
    end
    for (int k = 0; k < 20; k++) begin idle(); fu_rdy = 1'b1; step(); end
    #1;
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
